// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared constants for the memory access unit
package mem_access_unit_pkg;

  // Bus widths shared with the address and data registers
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;

  // Access sequencer state encodings
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Latched operation type
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // A write request always wins over a simultaneous read request
  function automatic logic pick_op(input logic wr);
    return wr ? OP_WR : OP_RD;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - asynchronous SRAM-style memory bus
interface mem_access_unit_if
  import mem_access_unit_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
);

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ce;
  logic          mem_oe;
  logic          mem_we;

  // Access unit side drives address, data and strobes
  modport master (
    output mem_addr, mem_wdata, mem_ce, mem_oe, mem_we,
    input  mem_rdata
  );

  // Memory side returns read data
  modport slave (
    input  mem_addr, mem_wdata, mem_ce, mem_oe, mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-access SRAM sequencer with programmable wait states
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int AW          = ADDR_W,
  parameter int DW          = DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW-1:0]      addr_in,
  input  logic [DW-1:0]      wdata_in,
  input  logic               rd_req,
  input  logic               wr_req,
  output logic               busy,
  output logic               done,
  output logic [DW-1:0]      rdata_out,
  mem_access_unit_if.master  mem
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic       ZERO_WAIT = (WAIT_CYCLES == 0);

  logic [1:0] state;
  logic [3:0] wait_cnt;
  logic       op;
  logic       last_strobe;

  // Final strobe cycle: SETUP with no wait states, or the WAIT cycle where the count hits 1
  always_comb begin
    last_strobe = 1'b0;
    if (state == S_SETUP)
      last_strobe = ZERO_WAIT;
    else if (state == S_WAIT)
      last_strobe = (wait_cnt <= 4'd1);
  end

  // Access sequencer: every output is a register updated here
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      wait_cnt      <= 4'd0;
      op            <= OP_RD;
      busy          <= 1'b0;
      done          <= 1'b0;
      rdata_out     <= '0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_ce    <= 1'b0;
      mem.mem_oe    <= 1'b0;
      mem.mem_we    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rd_req || wr_req) begin
            mem.mem_addr  <= addr_in;
            mem.mem_wdata <= wdata_in;
            op            <= pick_op(wr_req);
            mem.mem_ce    <= 1'b1;
            mem.mem_oe    <= !wr_req;
            mem.mem_we    <= wr_req;
            busy          <= 1'b1;
            state         <= S_SETUP;
          end
        end
        S_SETUP, S_WAIT: begin
          if (state == S_SETUP)
            wait_cnt <= WAIT_LOAD;
          else
            wait_cnt <= wait_cnt - 4'd1;
          if (last_strobe) begin
            // Strobes drop on the same edge that captures read data
            mem.mem_ce <= 1'b0;
            mem.mem_oe <= 1'b0;
            mem.mem_we <= 1'b0;
            done       <= 1'b1;
            if (op == OP_RD)
              rdata_out <= mem.mem_rdata;
            state <= S_DONE;
          end else begin
            state <= S_WAIT;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side counterpart of the address register: consumes the 15-bit latched address plus a read or write command, and runs one access on an asynchronous SRAM-style bus.
- Inserts a programmable number of wait states.
- For reads, returns the captured data word; for either command, signals completion with a one-cycle done pulse.
- Sits between the CPU datapath registers and the external/program memory.

Parameters:
- AW, 15, address width; matches the address register width.
- DW, 16, data word width.
- WAIT_CYCLES, 2, memory wait states per access; legal range 0..15.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- addr_in  input  AW  access address, sampled at request acceptance.
- wdata_in  input  DW  write data, sampled at request acceptance.
- rd_req  input  1  read request, level, sampled only in IDLE.
- wr_req  input  1  write request, level, sampled only in IDLE.
- busy  output  1  high while an access is in progress (SETUP, WAIT or DONE).
- done  output  1  one-cycle pulse marking access completion.
- rdata_out  output  DW  last read data; held until the next read completes.
- mem_addr  output  AW  memory address bus.
- mem_wdata  output  DW  memory write data bus.
- mem_rdata  input  DW  memory read data bus.
- mem_ce  output  1  chip enable, active-high.
- mem_oe  output  1  output enable, active-high; read accesses only.
- mem_we  output  1  write enable, active-high; write accesses only.

Behaviour:
- Reset: state=IDLE, wait counter=0. Registers at 0: busy, done, rdata_out, mem_addr, mem_wdata, mem_ce, mem_oe, mem_we.
- All outputs are registered; no combinational path from any input to any output.

- FSM states: IDLE, SETUP, WAIT, DONE.
- IDLE:
  - If wr_req or rd_req is high, latch addr_in into mem_addr, latch wdata_in into mem_wdata, latch op type, then go to SETUP.
  - If both are high, the write wins: the read is dropped, not queued. This matches the later-enable-wins priority of the address register.
- SETUP (1 cycle):
  - mem_ce=1; mem_oe=1 for a read, mem_we=1 for a write.
  - Load wait counter with WAIT_CYCLES.
  - Next state: WAIT if WAIT_CYCLES>0, else DONE.
- WAIT:
  - Strobes held; counter decrements each cycle.
  - When the counter reaches 1, go to DONE on the next edge.
- Read data capture: rdata_out <= mem_rdata on the edge that leaves the last strobe cycle (last WAIT cycle, or SETUP when WAIT_CYCLES=0).
- Write timing: mem_we deasserts on that same edge, so address and data are stable for the full we pulse.
- DONE (1 cycle):
  - done=1; mem_ce, mem_oe and mem_we all 0; mem_addr and mem_wdata held.
  - Next state: IDLE.
- Latency: request sampled at edge T gives done high in cycle T+2+WAIT_CYCLES, measured from the first SETUP cycle = T+1.
- Minimum request spacing: 3+WAIT_CYCLES cycles.
- Requests while busy (SETUP, WAIT, DONE) are ignored; no queuing.
- A request held high through DONE is re-accepted in the following IDLE cycle. Callers deassert the request on done.
- mem_oe and mem_we are never high simultaneously.
- rst mid-access: next edge forces IDLE and clears all strobes. No done is issued, rdata_out is cleared to 0, and the partial write is abandoned.
- Address wrap is not applicable: the address is used verbatim, all AW bits.

Decomposition:
- Shared package/include holds:
  - state encodings: IDLE=2'd0, SETUP=2'd1, WAIT=2'd2, DONE=2'd3
  - AW and DW defaults, shared with the address register and the data register
  - the op-type constants OP_RD=1'b0 and OP_WR=1'b1
- Optional sub-module: mem_wait_counter, a loadable 4-bit down-counter with a zero flag. Inlining it is acceptable.
- No further hierarchy.

Test Plan (WAIT_CYCLES=2 unless stated):
- Read: rd_req=1 at T with addr_in=15'h1234; mem_rdata=16'hBEEF during strobes -> mem_addr=15'h1234 from T+1, mem_oe=1 for cycles T+1..T+3, done=1 only in T+4, rdata_out=16'hBEEF from T+4 onward.
- Write: wr_req=1 with addr_in=15'h7FFF, wdata_in=16'hA5A5 -> mem_we=1 for exactly 3 cycles with mem_addr=15'h7FFF and mem_wdata=16'hA5A5 stable throughout; mem_oe=0 throughout; done pulses once.
- Simultaneous rd_req=wr_req=1 with addr_in=15'h0010 -> write performed (mem_we high, mem_oe never high); rdata_out unchanged.
- Request while busy: new rd_req with addr_in=15'h0055 during WAIT -> ignored; mem_addr stays at the first address; exactly one done.
- Reset mid-WAIT: rst=1 for one cycle during a write -> next cycle all strobes 0, busy=0, rdata_out=0, and no done pulse occurs.
- WAIT_CYCLES=0 build: read of 15'h0001 returning 16'h0F0F -> mem_oe high for 1 cycle, done in T+2, rdata_out=16'h0F0F.
